// File: rtl/spi_burst_seq.sv
// Register-access sequencer in front of the SPI byte engine: one request becomes
// an address byte plus 0..MAX_LEN data bytes. Optional inter-byte gap: SPI_SEQ_GAP_EN.
module spi_burst_seq #(
  parameter int N       = 8,
  parameter int MAX_LEN = 4,
`ifdef SPI_SEQ_GAP_EN
  parameter int GAP     = 4,
`endif
  parameter int TIMEOUT = 255
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [N-2:0]                 req_addr,
  input  logic [$clog2(MAX_LEN+1)-1:0] req_len,
  input  logic [MAX_LEN*N-1:0]         req_wdata,
  input  logic                         spi_ready,
  output logic                         spi_send,
  output logic [N-1:0]                 spi_data,
  input  logic                         spi_arrived,
  input  logic [N-1:0]                 spi_dataO,
  output logic                         rsp_valid,
  output logic [MAX_LEN*N-1:0]         rsp_rdata,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [2:0]                   state_dbg
);
  // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
  // spi_send is a one-cycle pulse, spi_arrived a one-cycle completion pulse,
  // rsp_valid a one-cycle pulse with rsp_rdata/rsp_err valid alongside it.

  localparam int LW = $clog2(MAX_LEN+1);
  localparam int IW = $clog2(MAX_LEN+2);
  localparam int CW = $clog2(TIMEOUT+1);
  localparam int W  = MAX_LEN*N;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_GAP} state_t;

  state_t          state_q, state_d;
  logic            wr_q;
  logic [N-2:0]    addr_q;
  logic [LW-1:0]   len_q;
  logic [W-1:0]    wdata_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    tx_byte;
  logic            issue, adv, tmo;
`ifdef SPI_SEQ_GAP_EN
  localparam int GW = $clog2(GAP+1);
  logic [GW-1:0]   gap_q;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign state_dbg = state_q;

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    adv     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_ISSUE;
      S_ISSUE: if (spi_ready) begin
        issue   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // arrived takes priority over the timeout terminal count
        if (spi_arrived) begin
          adv = 1'b1;
          if (idx_q == IW'(len_q)) state_d = S_DONE;
`ifdef SPI_SEQ_GAP_EN
          else                     state_d = S_GAP;
`else
          else                     state_d = S_ISSUE;
`endif
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          tmo     = 1'b1;
          state_d = S_DONE;
        end
      end
`ifdef SPI_SEQ_GAP_EN
      S_GAP:   if (gap_q == GW'(GAP-1)) state_d = S_ISSUE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address/command byte first, then write data or dummy bytes for reads.
  always_comb begin
    tx_byte = '0;
    if (idx_q == '0) tx_byte = {wr_q, addr_q};
    else if (wr_q) begin
      for (int k = 0; k < MAX_LEN; k++)
        if (idx_q == IW'(k+1)) tx_byte = wdata_q[(MAX_LEN-1-k)*N +: N];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      spi_send  <= 1'b0;
      spi_data  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      spi_send <= issue;
      if (state_q == S_IDLE && req_valid) begin
        wr_q      <= req_wr;
        addr_q    <= req_addr;
        len_q     <= (req_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : req_len;
        wdata_q   <= req_wdata;
        idx_q     <= '0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
      if (issue) begin
        spi_data <= tx_byte;
        cnt_q    <= '0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (adv) begin
        idx_q <= idx_q + IW'(1);
        if (!wr_q) begin
          for (int k = 0; k < MAX_LEN; k++)
            if (idx_q == IW'(k+1)) rsp_rdata[(MAX_LEN-1-k)*N +: N] <= spi_dataO;
        end
      end
      if (tmo) rsp_err <= 1'b1;
    end
  end

`ifdef SPI_SEQ_GAP_EN
  always_ff @(posedge Clock) begin
    if (Reset || adv)        gap_q <= '0;
    else if (state_q == S_GAP) gap_q <= gap_q + GW'(1);
  end
`endif

endmodule

// File: tb/tb_spi_burst_seq.sv
// Randomized scoreboard bench for spi_burst_seq with a behavioural SPI master model.
module tb_spi_burst_seq;
  localparam int N = 8, MAX_LEN = 4, TIMEOUT = 20, W = 32;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          req_valid, req_ready, req_wr;
  logic [6:0]    req_addr;
  logic [2:0]    req_len;
  logic [W-1:0]  req_wdata;
  logic          spi_ready, spi_send, spi_arrived;
  logic [7:0]    spi_data, spi_dataO;
  logic          rsp_valid, rsp_err, busy;
  logic [W-1:0]  rsp_rdata;
  logic [2:0]    state_dbg;

  spi_burst_seq #(.N(N), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .spi_ready(spi_ready), .spi_send(spi_send), .spi_data(spi_data),
    .spi_arrived(spi_arrived), .spi_dataO(spi_dataO),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---- clock / reset ----
  always #5 Clock = ~Clock;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---- scoreboard state ----
  logic [W:0]  exp_q[$];       // {err, rdata}
  logic [7:0]  exp_byte_q[$];  // bytes expected on spi_data
  logic [7:0]  slave_q[$];     // bytes the master returns
  logic [7:0]  sb_preset[$];
  int checks = 0, errors = 0;
  int sends_cnt = 0, last_send_cyc = 0;
  bit ready_force = 1'b1, no_arrive = 1'b0, abort = 1'b0, mbusy = 1'b0, ready_due = 1'b0;

  assign spi_ready = ready_force && !mbusy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // ---- master model: answers each spi_send after a random byte time ----
  initial begin
    logic [7:0] sent;
    spi_arrived = 1'b0;
    spi_dataO   = '0;
    forever begin
      @(negedge Clock);
      spi_arrived = 1'b0;
      if (spi_send && !no_arrive) begin
        sent  = spi_data;
        mbusy = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge Clock);
        if (!abort) chk("spi_data_stable", spi_data, sent);
        spi_dataO   = (slave_q.size() != 0) ? slave_q.pop_front() : 8'($urandom);
        spi_arrived = 1'b1;
        mbusy       = 1'b0;
      end
    end
  end

  // ---- monitor: bytes sent to the master ----
  initial forever begin
    @(negedge Clock);
    if (spi_send) begin
      sends_cnt++;
      last_send_cyc = cyc;
      if (exp_byte_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_send: got 0x%0h expected none", spi_data);
      end else chk("spi_data", spi_data, exp_byte_q.pop_front());
    end
  end

  // ---- monitor: responses ----
  initial forever begin
    logic [W:0] e;
    @(negedge Clock);
    if (ready_due) begin
      chk("req_ready_after_rsp", req_ready, 1);
      ready_due = 1'b0;
    end
    if (rsp_valid) begin
      ready_due = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got 0x%0h expected none", {rsp_err, rsp_rdata});
      end else begin
        e = exp_q.pop_front();
        chk("rsp", {rsp_err, rsp_rdata}, e);
        if (e[W]) chk("timeout_latency", cyc - last_send_cyc, TIMEOUT);
      end
    end
  end

  // ---- driver: reference model + request handshake ----
  task automatic issue_req(input logic wr, input logic [6:0] addr, input logic [2:0] len,
                           input logic [W-1:0] wdata, input bit tmo);
    int l, n;
    logic [7:0]   b;
    logic [W-1:0] rd;
    l  = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
    rd = '0;
    exp_byte_q.push_back({wr, addr});
    if (!tmo) begin
      for (int k = 0; k < l; k++)
        exp_byte_q.push_back(wr ? 8'(wdata >> (8*(3-k))) : 8'h00);
      for (int k = 0; k <= l; k++) begin
        b = (sb_preset.size() != 0) ? sb_preset.pop_front() : 8'($urandom);
        slave_q.push_back(b);
        if (k > 0 && !wr) rd = rd | (W'(b) << (8*(4-k)));
      end
    end
    exp_q.push_back(tmo ? {1'b1, 32'h0} : {1'b0, rd});
    @(negedge Clock);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_len = len; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge Clock); n++; end
    if (!req_ready) bound_fail("req_accept");
    @(negedge Clock);
    req_valid = 1'b0;
    req_wdata = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || exp_byte_q.size() != 0 || busy || mbusy) && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 3000) bound_fail("wait_done");
    repeat (2) @(negedge Clock);
  endtask

  initial begin
    int base, n;
    logic [7:0] held;
    Reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0; req_wdata = '0;
    repeat (3) @(negedge Clock);
    chk("rst_spi_send", spi_send, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    // write burst, address phase 8'h92
    issue_req(1'b1, 7'h12, 3'd2, 32'hA55A_0000, 1'b0);
    wait_done();

    // read burst with fixed slave bytes -> rdata 32'h1122_3300
    sb_preset.push_back(8'hFF); sb_preset.push_back(8'h11);
    sb_preset.push_back(8'h22); sb_preset.push_back(8'h33);
    issue_req(1'b0, 7'h05, 3'd3, 32'h0, 1'b0);
    wait_done();

    // oversize length clamps to MAX_LEN data bytes
    base = sends_cnt;
    issue_req(1'b1, 7'h2A, 3'd7, 32'hDEAD_BEEF, 1'b0);
    wait_done();
    chk("len_clamp_sends", sends_cnt - base, 5);

    // master not ready: no send, spi_data stable
    ready_force = 1'b0;
    issue_req(1'b1, 7'h41, 3'd1, 32'hC300_0000, 1'b0);
    held = spi_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk("stall_no_send", spi_send, 0);
      chk("stall_data_stable", spi_data, held);
    end
    ready_force = 1'b1;
    wait_done();

    // timeout: master never answers
    no_arrive = 1'b1;
    issue_req(1'b0, 7'h33, 3'd2, 32'h0, 1'b1);
    wait_done();
    no_arrive = 1'b0;

    // reset in the middle of a read
    base = sends_cnt;
    abort = 1'b1;
    issue_req(1'b0, 7'h07, 3'd3, 32'h0, 1'b0);
    n = 0;
    while (sends_cnt < base + 2 && n < 500) begin @(negedge Clock); n++; end
    if (n >= 500) bound_fail("abort_second_send");
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_busy", busy, 0);
    chk("abort_spi_send", spi_send, 0);
    chk("abort_rsp_rdata", rsp_rdata, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    Reset = 1'b0;
    exp_q.delete();
    n = 0;
    while (mbusy && n < 50) begin @(negedge Clock); n++; end
    repeat (4) @(negedge Clock);
    exp_byte_q.delete();
    slave_q.delete();
    abort = 1'b0;

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      issue_req(1'($urandom), 7'($urandom), 3'($urandom_range(0, 7)), W'($urandom), 1'b0);
      wait_done();
    end

    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_byte_q_empty", exp_byte_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end
endmodule

// File: doc/spi_burst_seq.md
Name: spi_burst_seq

Overview:
Transaction sequencer sitting directly upstream of the SPI master byte engine. It accepts one register-access request (read/write, address, 0..MAX_LEN data bytes) and breaks it into per-byte send/arrived handshakes with the master. On reads it collects the returned bytes into one response word. A per-byte timeout guards against a stalled master.

Parameters:
N, 8, SPI word width; must match the master's N.
MAX_LEN, 4, maximum data bytes per request.
TIMEOUT, 255, Clock cycles allowed between issuing a byte and its arrived pulse.

Ports:
Clock  input  1  system clock; all logic on its rising edge.
Reset  input  1  synchronous, active-high reset.
req_valid  input  1  request offered.
req_ready  output  1  high only in IDLE.
req_wr  input  1  1=write, 0=read.
req_addr  input  N-1  register address.
req_len  input  $clog2(MAX_LEN+1)  data byte count.
req_wdata  input  MAX_LEN*N  write bytes; byte 0 in the top N bits.
spi_ready  input  1  master idle.
spi_send  output  1  one-cycle start pulse to the master.
spi_data  output  N  byte to the master; held stable from the spi_send cycle until arrived.
spi_arrived  input  1  master byte-complete pulse.
spi_dataO  input  N  byte received by the master.
rsp_valid  output  1  one-cycle completion pulse.
rsp_rdata  output  MAX_LEN*N  read bytes; byte 0 in the top N bits.
rsp_err  output  1  timeout flag, valid with rsp_valid.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge):
  - FSM goes to IDLE.
  - spi_send=0, spi_data=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Reset mid-transaction abandons the transaction with no rsp_valid.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge: latch the request, clear rsp_rdata to 0, set byte index idx=0, go to ISSUE.
  - req_len>MAX_LEN is clamped to MAX_LEN at latch time.
- ISSUE, when spi_ready=1:
  - Drive spi_send=1 for exactly one cycle and go to WAIT.
  - spi_data by idx:
    - idx=0: {req_wr, req_addr}.
    - write, idx>0: byte idx-1 of the latched wdata.
    - read, idx>0: 8'h00 (dummy byte).
  - If spi_ready=0, stay in ISSUE with spi_send=0.
- WAIT, on spi_arrived=1:
  - Read with idx>0: store spi_dataO into rsp_rdata slot idx-1.
  - idx increments.
  - If the new idx equals len+1, go to DONE; otherwise go to ISSUE.
  - The response byte of the address phase is discarded.
- Timeout:
  - A counter runs in WAIT and is cleared on entry to WAIT.
  - If it reaches TIMEOUT with no arrived, set rsp_err=1 and go to DONE.
  - A late arrived in IDLE is ignored.
- DONE:
  - rsp_valid=1 for one cycle, then IDLE.
  - rsp_rdata and rsp_err hold until the next accepted request.
  - rsp_err is cleared when the next request is latched.
- Latency: minimum request-to-rsp_valid time is 1 + (len+1)·(master byte time + 2) cycles.
- len=0: address byte only; rsp_rdata=0.
- Simultaneous arrived and timeout terminal count: arrived wins.
- Unused rsp_rdata slots are 0.

Optional Feature:
Macro SPI_SEQ_GAP_EN.
- When defined: parameter GAP (default 4) adds a GAP state between WAIT and ISSUE. The sequencer idles there for GAP cycles before issuing the next byte, giving the slave inter-byte settling time. No gap follows the final byte.
- When undefined: WAIT goes straight to ISSUE and the GAP parameter is unused.

Test Plan:
1. Write: addr 7'h12, len=2, wdata 32'hA55A_0000, master model echoing -> spi_data sequence 8'h92, 8'hA5, 8'h5A; one rsp_valid; rsp_err=0.
2. Read: addr 7'h05, len=3, slave returns 8'hFF (addr phase), 8'h11, 8'h22, 8'h33 -> sent bytes 8'h05, 00, 00, 00; rsp_rdata=32'h1122_3300.
3. Timeout: TIMEOUT=20, master never pulses arrived -> rsp_valid exactly 20 cycles after entering WAIT; rsp_err=1; req_ready=1 the next cycle.
4. Reset mid-read after the second byte is sent -> next cycle busy=0, spi_send=0, rsp_rdata=0, and no rsp_valid; a following request completes normally.
5. req_len=7 with MAX_LEN=4 -> exactly 5 spi_send pulses.
6. spi_ready held low for 10 cycles in ISSUE -> no spi_send until spi_ready rises; spi_data stable throughout. With SPI_SEQ_GAP_EN, GAP=4 -> exactly 4 idle cycles between arrived and the next spi_send.
